// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter error-count receiver.
//
// Holds the default chain width, the number of chains per frame, the frame
// length, the bit offset of each chain inside a frame (LSB-first, chain 0_0
// first), the receiver FSM state type and a small offset helper.
package shifter_pkg;

    localparam int DEFAULT_CHAIN_WIDTH = 16;
    localparam int NUM_CHAINS          = 4;
    localparam int FRAME_LEN           = NUM_CHAINS * DEFAULT_CHAIN_WIDTH;

    // Bit offsets of each chain count inside a frame at the default width.
    localparam int CHAIN_0_0_OFS = 0;
    localparam int CHAIN_0_1_OFS = 16;
    localparam int CHAIN_1_0_OFS = 32;
    localparam int CHAIN_1_1_OFS = 48;

    typedef enum logic {
        HUNT = 1'b0,   // waiting for SYNC to mark frame bit 0
        RECV = 1'b1    // aligned, shifting frame bits in
    } rx_state_e;

    // Offset of chain idx inside a frame for an arbitrary chain width.
    function automatic int chain_ofs(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/shifter_error_rx_if.sv
// Bundle of the serial input and parallel result signals of the receiver.
//
//   DATA_IN        serial frame data, one bit per clock
//   SYNC           marks the cycle that carries frame bit 0
//   RX_ERROR_*     last complete frame, one count per chain
//   FRAME_VALID    one-cycle pulse when RX_ERROR_* update
//   LOCKED         receiver aligned to the stream
//   FRAME_COUNT    completed frames, wrapping
//   SYNC_ERR_COUNT misalignment events, saturating
//
// master: the side producing the stream and reading the results.
// slave:  the receiver itself.
interface shifter_error_rx_if #(
    parameter int CHAIN_WIDTH    = shifter_pkg::DEFAULT_CHAIN_WIDTH,
    parameter int SYNC_ERR_WIDTH = 8
);

    logic                      DATA_IN;
    logic                      SYNC;
    logic [CHAIN_WIDTH-1:0]    RX_ERROR_0_0;
    logic [CHAIN_WIDTH-1:0]    RX_ERROR_0_1;
    logic [CHAIN_WIDTH-1:0]    RX_ERROR_1_0;
    logic [CHAIN_WIDTH-1:0]    RX_ERROR_1_1;
    logic                      FRAME_VALID;
    logic                      LOCKED;
    logic [15:0]               FRAME_COUNT;
    logic [SYNC_ERR_WIDTH-1:0] SYNC_ERR_COUNT;

    modport master (
        output DATA_IN,
        output SYNC,
        input  RX_ERROR_0_0,
        input  RX_ERROR_0_1,
        input  RX_ERROR_1_0,
        input  RX_ERROR_1_1,
        input  FRAME_VALID,
        input  LOCKED,
        input  FRAME_COUNT,
        input  SYNC_ERR_COUNT
    );

    modport slave (
        input  DATA_IN,
        input  SYNC,
        output RX_ERROR_0_0,
        output RX_ERROR_0_1,
        output RX_ERROR_1_0,
        output RX_ERROR_1_1,
        output FRAME_VALID,
        output LOCKED,
        output FRAME_COUNT,
        output SYNC_ERR_COUNT
    );

endinterface

// File: rtl/shifter_error_rx_sat_counter.sv
// Saturating up-counter.
//
//   clk    clock
//   srst   synchronous active-high reset, clears the count
//   clr    synchronous clear, same effect as srst
//   inc    count up by one unless already all-ones
//   count  current value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/shifter_error_rx.sv
// Serial receiver for the shifter error-count stream.
//
// Reassembles a frame of four chain error counts sent LSB first (chain 0_0,
// 0_1, 1_0, 1_1) and presents them as parallel registers with a one-cycle
// FRAME_VALID strobe. Alignment comes from SYNC marking frame bit 0.
//
//   DATA_CLK  sole clock, all logic on posedge
//   RST       synchronous active-high reset
//   rx        slave side of shifter_error_rx_if (DATA_IN/SYNC in, results out)
module shifter_error_rx
    import shifter_pkg::*;
#(
    parameter int CHAIN_WIDTH    = DEFAULT_CHAIN_WIDTH,
    parameter int SYNC_REQUIRED  = 0,
    parameter int SYNC_ERR_WIDTH = 8
) (
    input  logic               DATA_CLK,
    input  logic               RST,
    shifter_error_rx_if.slave  rx
);

    localparam int FRAME_BITS = NUM_CHAINS * CHAIN_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

    rx_state_e               state_q;
    rx_state_e               state_d;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [CNT_W-1:0]        bit_cnt_d;
    logic [FRAME_BITS-1:0]   shreg_q;
    logic [FRAME_BITS-1:0]   shreg_d;
    logic [CHAIN_WIDTH-1:0]  rx_error_q [NUM_CHAINS];
    logic [CHAIN_WIDTH-1:0]  rx_error_d [NUM_CHAINS];
    logic                    frame_valid_q;
    logic                    frame_valid_d;
    logic [15:0]             frame_count_q;
    logic [15:0]             frame_count_d;
    logic                    locked;
    logic [SYNC_ERR_WIDTH-1:0] sync_err_count;

    // ------------------------------------------------------------------
    // Event decode for the current cycle
    // ------------------------------------------------------------------
    logic at_frame_start;
    logic at_last_bit;
    logic hunt_lock;     // SYNC seen while hunting
    logic misalign;      // SYNC on a bit other than bit 0
    logic missing_sync;  // bit 0 without SYNC while SYNC is mandatory
    logic accept;        // bit taken at its bit_cnt position
    logic sync_err_inc;

    always_comb begin
        at_frame_start = (bit_cnt_q == '0);
        at_last_bit    = (bit_cnt_q == LAST_IDX);
        hunt_lock      = (state_q == HUNT) && rx.SYNC;
        misalign       = (state_q == RECV) && rx.SYNC && !at_frame_start;
        missing_sync   = (state_q == RECV) && !rx.SYNC && at_frame_start
                         && (SYNC_REQUIRED != 0);
        accept         = (state_q == RECV) && !misalign && !missing_sync;
        sync_err_inc   = misalign || missing_sync;
    end

    // The completed frame is the shift register with the bit arriving this
    // cycle in the top position, so outputs can load on the same edge.
    logic [FRAME_BITS-1:0]  full_frame;
    logic [CHAIN_WIDTH-1:0] frame_chain [NUM_CHAINS];

    assign full_frame = {rx.DATA_IN, shreg_q[FRAME_BITS-2:0]};

    genvar gi;
    for (gi = 0; gi < NUM_CHAINS; gi++) begin : g_chain
        localparam int OFS = chain_ofs(gi, CHAIN_WIDTH);
        assign frame_chain[gi] = full_frame[OFS +: CHAIN_WIDTH];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge DATA_CLK) begin
        if (RST) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: begin
                if (rx.SYNC) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                // A misaligned SYNC re-aligns in place; only a missing
                // mandatory SYNC drops lock.
                if (missing_sync) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        locked = (state_q == RECV);
    end

    // ------------------------------------------------------------------
    // Datapath: bit counter, shift register, result registers, counters
    // ------------------------------------------------------------------
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        rx_error_d    = rx_error_q;
        frame_valid_d = 1'b0;
        frame_count_d = frame_count_q;

        if (hunt_lock || misalign) begin
            // Start a new frame; any partial frame is abandoned and its
            // stale bits are overwritten before the next frame completes.
            shreg_d[0] = rx.DATA_IN;
            bit_cnt_d  = CNT_W'(1);
        end else if (missing_sync) begin
            bit_cnt_d = '0;
        end else if (accept) begin
            shreg_d[bit_cnt_q] = rx.DATA_IN;
            if (at_last_bit) begin
                bit_cnt_d     = '0;
                frame_valid_d = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
                for (int i = 0; i < NUM_CHAINS; i++) begin
                    rx_error_d[i] = frame_chain[i];
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge DATA_CLK) begin
        if (RST) begin
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            for (int i = 0; i < NUM_CHAINS; i++) begin
                rx_error_q[i] <= '0;
            end
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            for (int i = 0; i < NUM_CHAINS; i++) begin
                rx_error_q[i] <= rx_error_d[i];
            end
        end
    end

    sat_counter #(
        .WIDTH (SYNC_ERR_WIDTH)
    ) u_sync_err_cnt (
        .clk   (DATA_CLK),
        .srst  (RST),
        .clr   (1'b0),
        .inc   (sync_err_inc),
        .count (sync_err_count)
    );

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign rx.RX_ERROR_0_0   = rx_error_q[0];
    assign rx.RX_ERROR_0_1   = rx_error_q[1];
    assign rx.RX_ERROR_1_0   = rx_error_q[2];
    assign rx.RX_ERROR_1_1   = rx_error_q[3];
    assign rx.FRAME_VALID    = frame_valid_q;
    assign rx.LOCKED         = locked;
    assign rx.FRAME_COUNT    = frame_count_q;
    assign rx.SYNC_ERR_COUNT = sync_err_count;

endmodule

// File: tb/tb_shifter_error_rx.sv
// Testbench for shifter_error_rx. Two receivers share one stimulus stream:
// dut0 free-runs after lock, dut1 requires SYNC on every frame. Frames that
// dut0 must deliver are pushed to a scoreboard when sent and popped by a
// negedge monitor when FRAME_VALID fires.
module tb_shifter_error_rx;
    import shifter_pkg::*;

    localparam int CW  = 16;
    localparam int SEW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shifter_error_rx_if #(.CHAIN_WIDTH(CW), .SYNC_ERR_WIDTH(SEW)) if0 ();
    shifter_error_rx_if #(.CHAIN_WIDTH(CW), .SYNC_ERR_WIDTH(SEW)) if1 ();

    shifter_error_rx #(
        .CHAIN_WIDTH(CW), .SYNC_REQUIRED(0), .SYNC_ERR_WIDTH(SEW)
    ) dut0 (
        .DATA_CLK (clk),
        .RST      (rst),
        .rx       (if0.slave)
    );

    shifter_error_rx #(
        .CHAIN_WIDTH(CW), .SYNC_REQUIRED(1), .SYNC_ERR_WIDTH(SEW)
    ) dut1 (
        .DATA_CLK (clk),
        .RST      (rst),
        .rx       (if1.slave)
    );

    typedef struct packed {
        logic [3:0][15:0] c;
        logic [15:0]      fc;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          fv0_cnt     = 0;
    int          fv1_cnt     = 0;
    int          fv0_last    = 0;
    int          fv0_prev    = 0;
    logic [15:0] exp_fc      = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor for dut0, pulse counter for dut1.
    always @(negedge clk) begin
        logic [3:0][15:0] act;
        exp_t e;
        if (if1.FRAME_VALID === 1'b1) fv1_cnt++;
        if (if0.FRAME_VALID === 1'b1) begin
            fv0_cnt++;
            fv0_prev = fv0_last;
            fv0_last = cyc;
            act[0] = if0.RX_ERROR_0_0;
            act[1] = if0.RX_ERROR_0_1;
            act[2] = if0.RX_ERROR_1_0;
            act[3] = if0.RX_ERROR_1_1;
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_frame: got frame %h at cycle %0d, required no frame", act, cyc);
            end else begin
                e = sb_q.pop_front();
                for (int i = 0; i < 4; i++) begin
                    vectors++;
                    if (act[i] !== e.c[i]) begin
                        miscompares++;
                        $display("FAIL sb_chain%0d: got %h, required %h", i, act[i], e.c[i]);
                    end
                end
                vectors++;
                if (if0.FRAME_COUNT !== e.fc) begin
                    miscompares++;
                    $display("FAIL sb_frame_count: got %0d, required %0d", if0.FRAME_COUNT, e.fc);
                end
                $display("frame @%0d: %h %h %h %h count %0d", cyc, act[0], act[1], act[2], act[3], if0.FRAME_COUNT);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [89:0] obs0();
        return {if0.RX_ERROR_0_0, if0.RX_ERROR_0_1, if0.RX_ERROR_1_0, if0.RX_ERROR_1_1,
                if0.FRAME_VALID, if0.LOCKED, if0.FRAME_COUNT, if0.SYNC_ERR_COUNT};
    endfunction

    function automatic logic [89:0] obs1();
        return {if1.RX_ERROR_0_0, if1.RX_ERROR_0_1, if1.RX_ERROR_1_0, if1.RX_ERROR_1_1,
                if1.FRAME_VALID, if1.LOCKED, if1.FRAME_COUNT, if1.SYNC_ERR_COUNT};
    endfunction

    function automatic logic [63:0] mk(input logic [15:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    // Drive one bit, let the receivers sample it, return 1 time unit later.
    task automatic step(input logic d, input logic s);
        if0.DATA_IN = d;
        if1.DATA_IN = d;
        if0.SYNC    = s;
        if1.SYNC    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input logic [63:0] f, input int lo, input int hi, input logic sync_first);
        for (int i = lo; i <= hi; i++) begin
            step(f[i], sync_first && (i == lo));
        end
    endtask

    task automatic push_exp(input logic [63:0] f);
        exp_t e;
        exp_fc = exp_fc + 16'd1;
        e.c    = f;
        e.fc   = exp_fc;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        rst = 1'b0;
        sb_q.delete();
        exp_fc = 16'd0;
    endtask

    task automatic test_reset();
        int bad;
        int n0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom), 1'($urandom));
            vectors++;
            if ((obs0() !== 90'd0) || (obs1() !== 90'd0)) begin
                miscompares++;
                $display("FAIL reset_outputs: got %h / %h, required all zero", obs0(), obs1());
            end
        end
        rst = 1'b0;
        n0  = fv0_cnt;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'($urandom), 1'b0);
            if ((obs0() !== 90'd0) || (obs1() !== 90'd0)) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL idle_no_sync: got %0d non-zero cycles, required 0", bad);
        end
        vectors++;
        if (fv0_cnt !== n0) begin
            miscompares++;
            $display("FAIL idle_no_frame: got %0d frames, required 0", fv0_cnt - n0);
        end
    endtask

    task automatic test_single_frame();
        logic [63:0] f;
        int n0;
        do_reset();
        n0 = fv0_cnt;
        f  = mk(16'h1234, 16'hABCD, 16'h0001, 16'h8000);
        push_exp(f);
        send_range(f, 0, 62, 1'b1);
        vectors++;
        if (if0.FRAME_VALID !== 1'b0 || if0.LOCKED !== 1'b1) begin
            miscompares++;
            $display("FAIL single_before_last: got fv=%b locked=%b, required fv=0 locked=1", if0.FRAME_VALID, if0.LOCKED);
        end
        step(f[63], 1'b0);
        vectors++;
        if (if0.FRAME_VALID !== 1'b1 || if0.FRAME_COUNT !== 16'd1) begin
            miscompares++;
            $display("FAIL single_valid: got fv=%b count=%0d, required fv=1 count=1", if0.FRAME_VALID, if0.FRAME_COUNT);
        end
        step(1'b0, 1'b0);
        vectors++;
        if (if0.FRAME_VALID !== 1'b0 || if0.RX_ERROR_0_1 !== 16'hABCD) begin
            miscompares++;
            $display("FAIL single_pulse_hold: got fv=%b 0_1=%h, required fv=0 0_1=abcd", if0.FRAME_VALID, if0.RX_ERROR_0_1);
        end
        vectors++;
        if (fv0_cnt - n0 !== 1) begin
            miscompares++;
            $display("FAIL single_pulse_count: got %0d pulses, required 1", fv0_cnt - n0);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] f;
        int n0;
        do_reset();
        n0 = fv0_cnt;
        for (int k = 0; k < 3; k++) begin
            f = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            push_exp(f);
            send_range(f, 0, 63, k == 0);
        end
        step(1'b0, 1'b0);
        vectors++;
        if (fv0_cnt - n0 !== 3 || fv0_last - fv0_prev !== 64) begin
            miscompares++;
            $display("FAIL b2b_pulses: got %0d pulses spacing %0d, required 3 spacing 64", fv0_cnt - n0, fv0_last - fv0_prev);
        end
        vectors++;
        if (if0.FRAME_COUNT !== 16'd3 || if0.SYNC_ERR_COUNT !== 8'd0) begin
            miscompares++;
            $display("FAIL b2b_counts: got frames=%0d syncerr=%0d, required 3 and 0", if0.FRAME_COUNT, if0.SYNC_ERR_COUNT);
        end
    endtask

    task automatic test_misalign();
        logic [63:0] p;
        logic [63:0] f;
        int n0;
        int t0;
        do_reset();
        n0 = fv0_cnt;
        p  = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        send_range(p, 0, 19, 1'b1);
        t0 = cyc;
        f  = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        push_exp(f);
        send_range(f, 0, 63, 1'b1);
        step(1'b0, 1'b0);
        vectors++;
        if (fv0_cnt - n0 !== 1 || fv0_last - t0 !== 64) begin
            miscompares++;
            $display("FAIL misalign_timing: got %0d pulses at +%0d, required 1 at +64", fv0_cnt - n0, fv0_last - t0);
        end
        vectors++;
        if (if0.SYNC_ERR_COUNT !== 8'd1) begin
            miscompares++;
            $display("FAIL misalign_syncerr: got %0d, required 1", if0.SYNC_ERR_COUNT);
        end
    endtask

    task automatic test_sync_required();
        logic [63:0] f;
        logic [63:0] g;
        int n1;
        do_reset();
        n1 = fv1_cnt;
        f  = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        g  = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        push_exp(f);
        send_range(f, 0, 63, 1'b1);
        vectors++;
        if (if1.LOCKED !== 1'b1 || if1.FRAME_VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL sreq_first: got locked=%b fv=%b, required 1 1", if1.LOCKED, if1.FRAME_VALID);
        end
        push_exp(g);
        step(g[0], 1'b0);
        vectors++;
        if (if1.LOCKED !== 1'b0 || if1.SYNC_ERR_COUNT !== 8'd1) begin
            miscompares++;
            $display("FAIL sreq_drop: got locked=%b syncerr=%0d, required 0 1", if1.LOCKED, if1.SYNC_ERR_COUNT);
        end
        send_range(g, 1, 63, 1'b0);
        step(1'b0, 1'b0);
        vectors++;
        if (fv1_cnt - n1 !== 1 || if1.SYNC_ERR_COUNT !== 8'd1 || if1.LOCKED !== 1'b0) begin
            miscompares++;
            $display("FAIL sreq_no_second: got pulses=%0d syncerr=%0d locked=%b, required 1 1 0", fv1_cnt - n1, if1.SYNC_ERR_COUNT, if1.LOCKED);
        end
        vectors++;
        if (if0.FRAME_COUNT !== 16'd2 || if0.SYNC_ERR_COUNT !== 8'd0) begin
            miscompares++;
            $display("FAIL sreq_freerun: got frames=%0d syncerr=%0d, required 2 0", if0.FRAME_COUNT, if0.SYNC_ERR_COUNT);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] f;
        logic [63:0] g;
        int n0;
        int bad;
        do_reset();
        f = mk(16'($urandom) | 16'h1, 16'($urandom), 16'($urandom), 16'($urandom));
        g = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        push_exp(f);
        send_range(f, 0, 63, 1'b1);
        send_range(g, 0, 39, 1'b0);
        rst = 1'b1;
        step(g[40], 1'b0);
        vectors++;
        if (obs0() !== 90'd0) begin
            miscompares++;
            $display("FAIL rst_mid_frame: got %h, required all zero", obs0());
        end
        rst = 1'b0;
        n0  = fv0_cnt;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'($urandom), 1'b0);
            if (obs0() !== 90'd0) bad++;
        end
        vectors++;
        if (bad !== 0 || fv0_cnt !== n0) begin
            miscompares++;
            $display("FAIL rst_hunt_after: got %0d non-zero cycles %0d frames, required 0 0", bad, fv0_cnt - n0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        step(1'b0, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            step(1'($urandom), 1'b1);
            if (i == 1 || i == 254 || i == 255 || i == 300) begin
                vectors++;
                if (if0.SYNC_ERR_COUNT !== SEW'((i > 255) ? 255 : i)) begin
                    miscompares++;
                    $display("FAIL sat_count_%0d: got %0d, required %0d", i, if0.SYNC_ERR_COUNT, (i > 255) ? 255 : i);
                end
            end
        end
        vectors++;
        if (if1.SYNC_ERR_COUNT !== 8'd255 || if0.FRAME_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_dut1: got syncerr=%0d fv=%b, required 255 0", if1.SYNC_ERR_COUNT, if0.FRAME_VALID);
        end
    endtask

    initial begin
        rst = 1'b1;
        if0.DATA_IN = 1'b0;
        if1.DATA_IN = 1'b0;
        if0.SYNC    = 1'b0;
        if1.SYNC    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_misalign();
        test_sync_required();
        test_reset_mid_frame();
        test_saturation();
        do_reset();
        vectors++;
        if (sb_q.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d frames still expected, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shifter_error_rx.md
Name: shifter_error_rx

Overview:
- Serial receiver for the shifter error-count stream.
- Samples one bit per DATA_CLK. Reassembles a 64-bit frame made of four 16-bit chain error counts: chain 0_0 first, then 0_1, 1_0, 1_1, each LSB first.
- Presents the four counts as parallel registers with a frame-valid strobe.
- Sits on the bench/capture side, consuming the serial error output of the chain-test logic.

Parameters:
- CHAIN_WIDTH, 16, bits per chain count. Frame length FRAME_LEN = 4*CHAIN_WIDTH.
- SYNC_REQUIRED, 0, 1 = SYNC must accompany bit 0 of every frame; 0 = free-run after first lock.
- SYNC_ERR_WIDTH, 8, width of the saturating sync-error counter.

Ports:
- DATA_CLK  input  1  sole clock; all logic on posedge.
- RST  input  1  synchronous reset, active-high.
- DATA_IN  input  1  serial data, one bit per DATA_CLK.
- SYNC  input  1  high in the cycle DATA_IN carries frame bit 0.
- RX_ERROR_0_0  output  CHAIN_WIDTH  last complete frame, frame bits [CHAIN_WIDTH-1:0].
- RX_ERROR_0_1  output  CHAIN_WIDTH  frame bits [2*CHAIN_WIDTH-1:CHAIN_WIDTH].
- RX_ERROR_1_0  output  CHAIN_WIDTH  next chain.
- RX_ERROR_1_1  output  CHAIN_WIDTH  last chain.
- FRAME_VALID  output  1  one-cycle pulse when the RX_ERROR_* outputs update.
- LOCKED  output  1  high while the FSM is in RECV.
- FRAME_COUNT  output  16  completed frames, wraps 0xFFFF->0.
- SYNC_ERR_COUNT  output  SYNC_ERR_WIDTH  misalignment events, saturating at all-ones.

Behaviour:
- Reset (RST high at posedge): every output is 0, the FSM goes to HUNT, bit_cnt = 0, and the shift register is cleared. Reset mid-frame discards the partial frame and holds the outputs at 0.
- FSM states are HUNT and RECV. bit_cnt counts 0..FRAME_LEN-1 and gives the index of the next bit expected.
- HUNT:
  - DATA_IN is ignored until SYNC = 1.
  - On SYNC: DATA_IN is stored as bit 0, bit_cnt becomes 1, and the FSM goes to RECV.
- RECV, normal operation:
  - Each cycle, DATA_IN is stored at index bit_cnt (LSB-first placement) and bit_cnt increments.
- RECV, last bit (bit_cnt = FRAME_LEN-1, no SYNC):
  - On the same edge, RX_ERROR_* load the full frame including the current bit.
  - FRAME_VALID is high for exactly the next cycle.
  - FRAME_COUNT increments and bit_cnt wraps to 0.
  - Latency is 1 cycle from the last bit sampled to outputs visible.
- RECV, bit_cnt = 0 with SYNC = 1: alignment is confirmed and the bit is handled normally.
- RECV, bit_cnt = 0 with SYNC = 0:
  - SYNC_REQUIRED = 0: the bit is accepted as bit 0, free-running.
  - SYNC_REQUIRED = 1: SYNC_ERR_COUNT increments, the FSM goes to HUNT, the bit is discarded, and LOCKED drops the next cycle.
- RECV, bit_cnt != 0 with SYNC = 1 (misalignment, including bit_cnt = FRAME_LEN-1):
  - The partial frame is discarded; no FRAME_VALID and no output update.
  - SYNC_ERR_COUNT increments.
  - DATA_IN is stored as bit 0, bit_cnt becomes 1, and the FSM stays in RECV.
- RX_ERROR_* hold their value between frames. Partial frames never reach the outputs.
- Counters: FRAME_COUNT wraps modulo 2^16. SYNC_ERR_COUNT saturates and never wraps.
- DATA_IN and SYNC are synchronous to DATA_CLK. The block adds no synchronizers.

Decomposition:
- Shared package shifter_pkg holds:
  - CHAIN_WIDTH default and NUM_CHAINS = 4;
  - FRAME_LEN;
  - chain offset constants CHAIN_0_0_OFS = 0, CHAIN_0_1_OFS = 16, CHAIN_1_0_OFS = 32, CHAIN_1_1_OFS = 48;
  - the FSM state enum (HUNT, RECV).
- One sub-module, sat_counter: parameterized width with inc and clr inputs, saturating. It is used for SYNC_ERR_COUNT.
- The rest of the logic stays in a single module.

Test Plan:
- RST high for 3 cycles, then stimulus with SYNC = 0 for 100 cycles -> all outputs 0, LOCKED = 0, no FRAME_VALID.
- SYNC on bit 0 of a frame encoding 0x1234, 0xABCD, 0x0001, 0x8000 (LSB-first, 64 cycles) -> FRAME_VALID pulses once, 1 cycle after bit 63. Outputs read 0_0 = 0x1234, 0_1 = 0xABCD, 1_0 = 0x0001, 1_1 = 0x8000. FRAME_COUNT = 1.
- Three back-to-back frames, SYNC only on the first, SYNC_REQUIRED = 0 -> three FRAME_VALID pulses 64 cycles apart, FRAME_COUNT = 3, SYNC_ERR_COUNT = 0.
- SYNC reasserted at bit 20 of a frame, then a clean frame 0xFFFF×4 -> no output update at the aborted frame, SYNC_ERR_COUNT = 1. The next FRAME_VALID comes 64 cycles after the re-sync with all outputs 0xFFFF.
- SYNC_REQUIRED = 1, second frame sent without SYNC -> LOCKED drops 1 cycle after the missing bit 0, SYNC_ERR_COUNT = 1, no second FRAME_VALID.
- RST asserted at bit 40 of the second frame -> outputs return to 0 next cycle and FSM is in HUNT. Separately, force 300 misalignments -> SYNC_ERR_COUNT holds at 255.
